fsm_serial_tx: RTL and testbench
================================

// Module: fsm_serial_tx
// PURPOSE
//  Transmit-side counterpart to the two-state serial follower FSM.
//  Accepts a WIDTH-bit word via valid/ready handshake and drives it onto a single serial line.
//  Frame format: one start cycle (out=1), the data bits MSB-first, then GAP_CYCLES idle-low cycles.
//  The frame repeats (load_repeat+1) times; the block then returns to IDLE.
//  It drives the `in` pin of the serial receiver/follower FSM in loopback and system tests.
// PARAMETERS
//  WIDTH      8  data bits per frame, >=1
//  GAP_CYCLES 2  low cycles after each frame's data, >=0 (0 = no gap)
//  REPEAT_W   4  width of load_repeat; frames sent = load_repeat+1 (1..2**REPEAT_W)
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  rst          in   1         reset, synchronous, active-high
//  load_valid   in   1         request to transmit load_data
//  load_ready   out  1         block can accept; high only in IDLE
//  load_data    in   WIDTH     word to send; captured at accept
//  load_repeat  in   REPEAT_W  extra repetitions; captured at accept
//  out          out  1         serial line, registered
//  busy         out  1         1 whenever state != IDLE
//  done         out  1         1-cycle pulse on the first IDLE cycle after the last frame
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, out=0, busy=0, done=0, load_ready=1 from the next cycle.
//    All counters and shadow registers are cleared.
//  - Reset mid-operation aborts immediately: the next cycle is IDLE with out=0 and no done pulse.
//  - Accept: load_valid && load_ready at a posedge captures load_data and load_repeat.
//    Later changes to either input are ignored until the next accept.
//    load_valid outside IDLE is ignored; nothing is queued.
//  - States: IDLE -> START -> SHIFT -> GAP -> (START | IDLE).
//  - IDLE:
//    - out=0, busy=0, load_ready=1.
//    - On accept, go to START.
//  - START:
//    - out=1 for exactly 1 cycle; bit index = WIDTH-1.
//    - Go to SHIFT.
//  - SHIFT:
//    - out = data[idx], with idx = WIDTH-1 down to 0; one bit per cycle, WIDTH cycles.
//    - After bit 0: go to GAP if GAP_CYCLES>0.
//    - Otherwise, if frames remain, go to START; else go to IDLE.
//  - GAP:
//    - out=0 for GAP_CYCLES cycles.
//    - Then go to START if frames remain, else go to IDLE.
//  - Frame counter:
//    - Loaded with load_repeat at accept.
//    - Decremented at each frame end (last data bit when GAP_CYCLES=0, otherwise last gap cycle).
//    - Counter 0 at frame end -> IDLE.
//    - No wrap: load_repeat = all-ones sends exactly 2**REPEAT_W frames.
//  - Frame length F = 1+WIDTH+GAP_CYCLES cycles.
//    busy is high for exactly (load_repeat+1)*F cycles, starting the cycle after accept.
//  - out, busy and done are all registered; out has 1-cycle latency from accept to the start bit.
//  - done=1 only in the first IDLE cycle after completion; load_ready is also 1 in that cycle.
//    A back-to-back accept there produces the next START on the following cycle, with no extra idle.
//  - Simultaneous rst and load_valid: rst wins; no accept.
// TESTING
//  - Reset: rst=1 for 2 cycles, load_valid=1 -> out=0, busy=0, done=0; no accept until rst=0.
//  - Single frame (WIDTH=8, GAP=2), data=0xA5, repeat=0, accepted at edge T0:
//    - cycles 1..11 out = 1,1,0,1,0,0,1,0,1,0,0;
//    - done=1 in cycle 12 only; busy=1 in cycles 1..11.
//  - Repeat: data=0x81, repeat=2 -> three identical 11-cycle frames;
//    busy for 33 cycles, one done pulse; load_data changed mid-send has no effect.
//  - Back-to-back: assert load_valid with 0xFF during the done cycle -> its START appears the next cycle.
//    load_valid asserted while busy -> load_ready=0, ignored.
//  - Abort: rst=1 in the 5th SHIFT cycle -> next cycle out=0, busy=0, done stays 0.
//    A new accept then sends a full fresh frame.
//  - GAP_CYCLES=0, WIDTH=1, data=0, repeat=1 -> out = 1,0,1,0; done in cycle 5.

Source files
------------

// File: rtl/fsm_serial_tx.sv
// Serial frame transmitter: each frame is a start pulse, the word MSB-first, then an
// idle-low gap. The frame is sent load_repeat+1 times per accepted word.
module fsm_serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned REPEAT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [WIDTH-1:0]    load_data,
    input  logic [REPEAT_W-1:0] load_repeat,
    output logic                out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [REPEAT_W-1:0] frames_q, frames_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            frames_q <= '0;
            data_q   <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            frames_q <= frames_d;
            data_q   <= data_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // Outputs are derived from the next state so they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        frames_d  = frames_q;
        data_d    = data_q;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_valid && ready_q) begin
                    data_d   = load_data;
                    frames_d = load_repeat;
                    idx_d    = IDX_W'(WIDTH - 1);
                    state_d  = S_START;
                end
            end
            S_START: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (GAP_CYCLES > 0) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    frame_end = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    frame_end = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame counter counts remaining extra frames; zero at frame end means finished.
        if (frame_end) begin
            if (frames_q == '0) begin
                state_d = S_IDLE;
            end else begin
                frames_d = frames_q - REPEAT_W'(1);
                idx_d    = IDX_W'(WIDTH - 1);
                state_d  = S_START;
            end
        end

        out_d   = (state_d == S_START) | ((state_d == S_SHIFT) & data_d[idx_d]);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q != S_IDLE) && (state_d == S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    assign out        = out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: a queue-based frame model checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_fsm_serial_tx;

    localparam int unsigned W0 = 8;
    localparam int unsigned G0 = 2;
    localparam int unsigned W1 = 1;
    localparam int unsigned G1 = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv0, lv1;
    logic [7:0] ld0;
    logic [0:0] ld1;
    logic [3:0] lr0, lr1;
    logic       out0, busy0, done0, rdy0;
    logic       out1, busy1, done1, rdy1;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    // Expected per-cycle values packed as {out, busy, done}.
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] cur0 = 3'b000;
    logic [2:0] cur1 = 3'b000;

    always #5 clk = ~clk;

    fsm_serial_tx #(.WIDTH(W0), .GAP_CYCLES(G0), .REPEAT_W(4)) dut0 (
        .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0),
        .load_data(ld0), .load_repeat(lr0), .out(out0), .busy(busy0), .done(done0)
    );

    fsm_serial_tx #(.WIDTH(W1), .GAP_CYCLES(G1), .REPEAT_W(4)) dut1 (
        .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1),
        .load_data(ld1), .load_repeat(lr1), .out(out1), .busy(busy1), .done(done1)
    );

    function automatic void chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endfunction

    function automatic void chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void push(input int which, input logic [2:0] e);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endfunction

    // Whole transaction: (rep+1) frames of start, MSB-first data, gap; then a done cycle.
    function automatic void push_frames(input int which, input logic [7:0] d, input int rep,
                                        input int w, input int g);
        for (int r = 0; r <= rep; r++) begin
            push(which, 3'b110);
            for (int i = w - 1; i >= 0; i--) push(which, {d[i], 2'b10});
            for (int k = 0; k < g; k++) push(which, 3'b010);
        end
        push(which, 3'b001);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            cur0 = 3'b000;
        end else begin
            if (!cur0[1] && lv0) push_frames(0, ld0, int'(lr0), int'(W0), int'(G0));
            cur0 = (q0.size() > 0) ? q0.pop_front() : 3'b000;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q1.delete();
            cur1 = 3'b000;
        end else begin
            if (!cur1[1] && lv1) push_frames(1, 8'(ld1), int'(lr1), int'(W1), int'(G1));
            cur1 = (q1.size() > 0) ? q1.pop_front() : 3'b000;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m0_out",   out0,  cur0[2]);
            chk("m0_busy",  busy0, cur0[1]);
            chk("m0_done",  done0, cur0[0]);
            chk("m0_ready", rdy0,  ~cur0[1]);
            chk("m1_out",   out1,  cur1[2]);
            chk("m1_busy",  busy1, cur1[1]);
            chk("m1_done",  done1, cur1[0]);
            chk("m1_ready", rdy1,  ~cur1[1]);
        end
    end

    initial begin
        logic [10:0] pat_a5;
        logic [3:0]  pat_w1;
        int          nbusy;
        int          ndone;

        pat_a5 = 11'b110_1001_0100;
        pat_w1 = 4'b1010;

        // Reset held with a pending request: nothing may be accepted.
        rst = 1'b1; lv0 = 1'b1; ld0 = 8'hA5; lr0 = 4'd0;
        lv1 = 1'b0; ld1 = 1'b0; lr1 = 4'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out", out0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        rst = 1'b0; lv0 = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame 0xA5.
        lv0 = 1'b1; ld0 = 8'hA5; lr0 = 4'd0;
        @(negedge clk);
        lv0 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("a5_out", out0, (k <= 11) ? pat_a5[11 - k] : 1'b0);
            chk("a5_busy", busy0, k <= 11);
            chk("a5_done", done0, k == 12);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Three repeats of 0x81 with ignored mid-send requests, then back-to-back 0xFF.
        lv0 = 1'b1; ld0 = 8'h81; lr0 = 4'd2;
        @(negedge clk);
        lv0 = 1'b0;
        nbusy = 0; ndone = 0;
        for (int k = 1; k <= 34; k++) begin
            if (busy0) nbusy++;
            if (done0) ndone++;
            if (k == 10) begin lv0 = 1'b1; ld0 = 8'h00; lr0 = 4'd5; end
            if (k == 10) chk("busy_ready", rdy0, 1'b0);
            if (k == 11) lv0 = 1'b0;
            if (k == 20) ld0 = 8'h7E;
            if (k == 34) begin lv0 = 1'b1; ld0 = 8'hFF; lr0 = 4'd0; end
            @(negedge clk);
        end
        lv0 = 1'b0;
        chk_int("rep_busy_cycles", nbusy, 33);
        chk_int("rep_done_pulses", ndone, 1);
        chk("b2b_start", out0, 1'b1);
        chk("b2b_busy", busy0, 1'b1);
        repeat (13) @(negedge clk);

        // Abort during the 5th data bit.
        lv0 = 1'b1; ld0 = 8'h3C; lr0 = 4'd1;
        @(negedge clk);
        lv0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out", out0, 1'b0);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_done", done0, 1'b0);
        @(negedge clk);
        chk("abort_done2", done0, 1'b0);
        lv0 = 1'b1; ld0 = 8'h5A; lr0 = 4'd0;
        @(negedge clk);
        lv0 = 1'b0;
        chk("fresh_start", out0, 1'b1);
        repeat (13) @(negedge clk);

        // WIDTH=1, no gap: data 0, two frames.
        lv1 = 1'b1; ld1 = 1'b0; lr1 = 4'd1;
        @(negedge clk);
        lv1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("w1_out", out1, (k <= 4) ? pat_w1[4 - k] : 1'b0);
            chk("w1_done", done1, k == 5);
            @(negedge clk);
        end

        // Maximum repeat count: 16 frames of 2 cycles each.
        lv1 = 1'b1; ld1 = 1'b1; lr1 = 4'hF;
        @(negedge clk);
        lv1 = 1'b0;
        nbusy = 0; ndone = 0;
        for (int k = 1; k <= 36; k++) begin
            if (busy1) nbusy++;
            if (done1) ndone++;
            @(negedge clk);
        end
        chk_int("max_rep_busy", nbusy, 32);
        chk_int("max_rep_done", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
